// File: rtl/regfile_pkg.sv
// Shared types for the register-file write path: widths and the queued write entry.
package regfile_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 1 << ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] rnum;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic [0:0] {SRC_A = 1'b0, SRC_B = 1'b1} src_t;
endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback entries; exposes its head and every slot so
// the parent can build the pending-write mask.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  wb_entry_t             din,
  input  logic                  pop,
  output wb_entry_t             head,
  output logic                  head_vld,
  output logic                  full,
  output wb_entry_t [DEPTH-1:0] slots,
  output logic [DEPTH-1:0]      slot_vld
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [PW:0]           count;
  wb_entry_t [DEPTH-1:0] mem;
  logic                  do_push, do_pop;

  // full comes from the registered count only, so a same-cycle pop cannot free a slot
  assign full     = (count == (PW+1)'(DEPTH));
  assign head_vld = (count != '0);
  assign head     = mem[rd_ptr];
  assign slots    = mem;
  assign do_push  = push && !full;
  assign do_pop   = pop && head_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // a slot is live if its distance from the read pointer is below the count
  always_comb begin
    slot_vld = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PW-1:0] off;
      off = PW'(i) - rd_ptr;
      slot_vld[i] = ({1'b0, off} < count);
    end
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Two writeback sources share the register file's single write port through
// per-source FIFOs, a round-robin arbiter and one registered write stage.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter bit DROP_R0    = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [ADDR_W-1:0]   a_reg,
  input  logic [DATA_W-1:0]   a_data,
  input  logic                b_valid,
  output logic                b_ready,
  input  logic [ADDR_W-1:0]   b_reg,
  input  logic [DATA_W-1:0]   b_data,
  input  logic                hold,
  output logic                rf_we,
  output logic [ADDR_W-1:0]   rf_wnum,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic [NUM_REGS-1:0] pend_mask
);
  wb_entry_t [1:0]                 din, head;
  wb_entry_t [1:0][FIFO_DEPTH-1:0] slots;
  logic [1:0][FIFO_DEPTH-1:0]      slot_vld;
  logic [1:0]                      push, pop, full, head_vld;
  src_t                            last_grant;
  wb_entry_t                       sel;

  assign din[0]  = '{rnum: a_reg, data: a_data};
  assign din[1]  = '{rnum: b_reg, data: b_data};
  assign push    = {b_valid, a_valid};
  assign a_ready = !full[0];
  assign b_ready = !full[1];

  for (genvar s = 0; s < 2; s++) begin : g_src
    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push[s]),
      .din      (din[s]),
      .pop      (pop[s]),
      .head     (head[s]),
      .head_vld (head_vld[s]),
      .full     (full[s]),
      .slots    (slots[s]),
      .slot_vld (slot_vld[s])
    );
  end

  // on a tie the source that did not win last time gets the port
  assign pop[0] = !hold && head_vld[0] && (!head_vld[1] || last_grant == SRC_B);
  assign pop[1] = !hold && head_vld[1] && (!head_vld[0] || last_grant == SRC_A);
  assign sel    = pop[1] ? head[1] : head[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= SRC_B;
      rf_we      <= 1'b0;
      rf_wnum    <= '0;
      rf_wdata   <= '0;
    end else if (|pop) begin
      last_grant <= pop[1] ? SRC_B : SRC_A;
      rf_we      <= !(DROP_R0 && sel.rnum == '0);
      rf_wnum    <= sel.rnum;
      rf_wdata   <= sel.data;
    end else begin
      rf_we      <= 1'b0;
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < FIFO_DEPTH; i++)
        if (slot_vld[s][i]) pend_mask[slots[s][i].rnum] = 1'b1;
    if (rf_we) pend_mask[rf_wnum] = 1'b1;
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed and random stimulus against a queue-based reference of the write arbiter.
module tb_regfile_write_arbiter;
  import regfile_pkg::*;
  localparam int D = 2;

  logic                clk = 1'b0;
  logic                rst, a_valid, b_valid, hold;
  logic [ADDR_W-1:0]   a_reg, b_reg;
  logic [DATA_W-1:0]   a_data, b_data;
  logic                a_ready, b_ready, rf_we;
  logic [ADDR_W-1:0]   rf_wnum;
  logic [DATA_W-1:0]   rf_wdata;
  logic [NUM_REGS-1:0] pend_mask;

  regfile_write_arbiter #(.FIFO_DEPTH(D), .DROP_R0(1'b1)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
    .hold(hold), .rf_we(rf_we), .rf_wnum(rf_wnum), .rf_wdata(rf_wdata),
    .pend_mask(pend_mask)
  );

  always #5 clk = ~clk;

  // reference: one queue per source, last winner, write stage contents
  wb_entry_t           qa[$], qb[$];
  bit                  m_last_b;
  bit                  m_we;
  logic [ADDR_W-1:0]   m_wnum;
  logic [DATA_W-1:0]   m_wdata;
  int                  n_chk = 0, n_pass = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_edge();
    bit ra, rb, ga, gb;
    wb_entry_t e;
    if (rst) begin
      qa.delete(); qb.delete();
      m_last_b = 1'b1; m_we = 1'b0; m_wnum = '0; m_wdata = '0;
      return;
    end
    ra = qa.size() < D;
    rb = qb.size() < D;
    ga = 1'b0; gb = 1'b0;
    if (!hold && qa.size() > 0 && (qb.size() == 0 || m_last_b)) ga = 1'b1;
    else if (!hold && qb.size() > 0) gb = 1'b1;
    e = '0;
    if (ga) begin e = qa.pop_front(); m_last_b = 1'b0; end
    else if (gb) begin e = qb.pop_front(); m_last_b = 1'b1; end
    if (ga || gb) begin
      m_we = (e.rnum != 0); m_wnum = e.rnum; m_wdata = e.data;
    end else m_we = 1'b0;
    if (a_valid && ra) qa.push_back('{rnum: a_reg, data: a_data});
    if (b_valid && rb) qb.push_back('{rnum: b_reg, data: b_data});
  endtask

  task automatic check_all();
    logic [NUM_REGS-1:0] m;
    m = '0;
    foreach (qa[i]) m[qa[i].rnum] = 1'b1;
    foreach (qb[i]) m[qb[i].rnum] = 1'b1;
    if (m_we) m[m_wnum] = 1'b1;
    chk("rf_we", 64'(rf_we), 64'(m_we));
    chk("rf_wnum", 64'(rf_wnum), 64'(m_wnum));
    chk("rf_wdata", 64'(rf_wdata), 64'(m_wdata));
    chk("a_ready", 64'(a_ready), 64'(qa.size() < D));
    chk("b_ready", 64'(b_ready), 64'(qb.size() < D));
    chk("pend_mask", 64'(pend_mask), 64'(m));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    rst = 1'b0; hold = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
  endtask

  initial begin
    int ia, ib, idx, first, last;
    int seq[$];
    int wr[$];
    bit acc_a, acc_b;
    wb_entry_t e4[3];

    // 1: reset then idle
    idle(); a_reg = '0; b_reg = '0; a_data = '0; b_data = '0;
    rst = 1'b1;
    @(posedge clk); model_edge();
    @(posedge clk); model_edge();
    @(negedge clk);
    rst = 1'b0;
    cycle();
    chk("t1_rf_we", 64'(rf_we), 64'd0);
    chk("t1_ready", 64'({a_ready, b_ready}), 64'd3);
    chk("t1_pend", 64'(pend_mask), 64'd0);

    // 2: single write latency
    a_valid = 1'b1; a_reg = 5'd5; a_data = 32'hDEAD_BEEF;
    cycle();
    idle();
    chk("t2_pend_q", 64'(pend_mask[5]), 64'd1);
    chk("t2_we_early", 64'(rf_we), 64'd0);
    cycle();
    chk("t2_we", 64'(rf_we), 64'd1);
    chk("t2_wnum", 64'(rf_wnum), 64'd5);
    chk("t2_wdata", 64'(rf_wdata), 64'hDEAD_BEEF);
    chk("t2_pend_ws", 64'(pend_mask[5]), 64'd1);
    cycle();
    chk("t2_we_after", 64'(rf_we), 64'd0);
    chk("t2_pend_after", 64'(pend_mask), 64'd0);

    // 3: both sources streaming from reset state
    rst = 1'b1; cycle(); rst = 1'b0;
    ia = 0; ib = 0; first = -1; last = -1;
    for (int c = 0; c < 80 && seq.size() < 16; c++) begin
      a_valid = (ia < 8); a_reg = ADDR_W'(1 + ia);  a_data = 32'hA000_0000 + ia;
      b_valid = (ib < 8); b_reg = ADDR_W'(11 + ib); b_data = 32'hB000_0000 + ib;
      acc_a = a_valid && a_ready;
      acc_b = b_valid && b_ready;
      cycle();
      if (acc_a) ia++;
      if (acc_b) ib++;
      if (rf_we) begin
        seq.push_back(int'(rf_wnum));
        if (first < 0) first = c;
        last = c;
      end
    end
    idle();
    chk("t3_count", 64'(seq.size()), 64'd16);
    for (int k = 0; k < 16 && k < seq.size(); k++)
      chk("t3_order", 64'(seq[k]), 64'((k % 2) ? 11 + k / 2 : 1 + k / 2));
    chk("t3_no_gap", 64'(last - first), 64'd15);
    for (int c = 0; c < 3; c++) cycle();

    // 4: hold with source A overflowing its FIFO
    e4[0] = '{rnum: 5'd21, data: 32'h1111};
    e4[1] = '{rnum: 5'd22, data: 32'h2222};
    e4[2] = '{rnum: 5'd23, data: 32'h3333};
    hold = 1'b1; idx = 0;
    for (int c = 0; c < 4; c++) begin
      a_valid = 1'b1; a_reg = e4[idx].rnum; a_data = e4[idx].data;
      acc_a = a_ready;
      cycle();
      if (acc_a) idx++;
    end
    chk("t4_accepted", 64'(idx), 64'd2);
    chk("t4_a_ready", 64'(a_ready), 64'd0);
    hold = 1'b0;
    for (int c = 0; c < 12; c++) begin
      a_valid = (idx < 3);
      if (idx < 3) begin a_reg = e4[idx].rnum; a_data = e4[idx].data; end
      acc_a = a_valid && a_ready;
      cycle();
      if (acc_a) idx++;
      if (rf_we) wr.push_back(int'(rf_wnum));
    end
    idle();
    chk("t4_writes", 64'(wr.size()), 64'd3);
    for (int k = 0; k < 3 && k < wr.size(); k++)
      chk("t4_order", 64'(wr[k]), 64'(21 + k));

    // 5: register 0 is consumed but never written
    b_valid = 1'b1; b_reg = '0; b_data = 32'h1234;
    cycle();
    idle();
    chk("t5_pend0", 64'(pend_mask[0]), 64'd1);
    cycle();
    chk("t5_we", 64'(rf_we), 64'd0);
    chk("t5_pend0_clr", 64'(pend_mask[0]), 64'd0);
    chk("t5_b_empty", 64'(b_ready), 64'd1);

    // 6: reset with both FIFOs loaded
    hold = 1'b1;
    a_valid = 1'b1; a_reg = 5'd7; a_data = 32'h77;
    b_valid = 1'b1; b_reg = 5'd9; b_data = 32'h99;
    cycle(); cycle();
    idle(); rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("t6_we", 64'(rf_we), 64'd0);
    chk("t6_pend", 64'(pend_mask), 64'd0);
    wr.delete();
    for (int c = 0; c < 4; c++) begin
      cycle();
      if (rf_we) wr.push_back(int'(rf_wnum));
    end
    chk("t6_no_emit", 64'(wr.size()), 64'd0);

    // random traffic with occasional reset
    for (int c = 0; c < 400; c++) begin
      rst     = ($urandom_range(0, 59) == 0);
      hold    = ($urandom_range(0, 4) == 0);
      a_valid = $urandom_range(0, 1);
      b_valid = $urandom_range(0, 1);
      a_reg   = ADDR_W'($urandom_range(0, NUM_REGS - 1));
      b_reg   = ADDR_W'($urandom_range(0, NUM_REGS - 1));
      a_data  = $urandom;
      b_data  = $urandom;
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
